mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped UART transmitter that sits as a responder on the core's data-RAM bus (ce/we/addr/data), in parallel with the data RAM, claiming a 16-byte window. Software writes bytes into a small TX FIFO; an internal FSM serialises them as 8N1 frames on `txd` at a programmable divisor. Reads return status and configuration with no side effects. This gives the minimal SOPC a console output path.

## Interface
- `BASE_ADDR`, 32'h1000_0000: window base; only `addr[31:4]` is compared.
- `CLK_DIV`, 16'd434: reset value of the divisor register, in clocks per bit.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two and ≥ 2.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce`  in  1  bus access strobe.
- `we`  in  1  1 = write, 0 = read; valid only when `ce` = 1.
- `addr`  in  32  byte address.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data; combinational.
- `txd`  out  1  serial output, registered; idles high.
- `tx_irq`  out  1  interrupt; present only with `UART_TX_IRQ_EN`.

## Operation
- **Hit**: `ce` = 1 and `addr[31:4]` = `BASE_ADDR[31:4]`. The register is selected by `addr[3:2]`.
- **Outside the window**: `data_o` = 0 and writes are ignored.
- **Reads**: `data_o` = 0 when there is no hit or `we` = 1.

Registers:
- **0x0 TXDATA** (W)
  - Writing pushes `data_i[7:0]` into the FIFO.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - Reads return 0.
- **0x4 STATUS** (R; W1C on bit 3)
  - bit0 `full`, bit1 `empty`, bit2 `busy` (FSM not IDLE), bit3 `ovf`.
  - bits[11:8] hold the FIFO occupancy count.
  - Writing 1 to bit3 clears `ovf`.
- **0x8 DIV** (R/W)
  - Bits [15:0] hold the divisor; the upper bits read 0.
  - Each bit lasts `max(DIV,1)` clocks.
- **0xC CTRL**: see Configuration.

FIFO:
- Push and pop in the same cycle leave the count unchanged.
- Fullness is judged on the pre-edge state. A push into a full FIFO is rejected even if a pop happens in the same cycle.

FSM states: IDLE, START, DATA, STOP.
- **IDLE**: `txd` = 1. If the FIFO is not empty, pop into the shift register, latch DIV into the bit timer, and go to START.
- **START**: `txd` = 0 for one bit time, then go to DATA with bit index 0.
- **DATA**: `txd` = `shift[0]`, LSB first. Shift right each bit time; after the 8th bit, go to STOP.
- **STOP**: `txd` = 1 for one bit time.
  - If the FIFO is not empty at the end of the stop bit, pop and go straight to START, so consecutive frames have no gap.
  - Otherwise go to IDLE.
- The bit timer reloads from DIV at every bit boundary. A DIV write in mid-frame therefore takes effect from the next bit boundary.

## Timing
- **Reset values**: `txd` = 1, FIFO empty, `ovf` = 0, DIV = `CLK_DIV`, CTRL = 0, `tx_irq` = 0, FSM in IDLE.
- **Reset mid-frame**: `txd` goes to 1 immediately (asynchronous) and all queued bytes are discarded.
- **Write latency**:
  - A TXDATA write to an empty FIFO with the FSM in IDLE is captured at edge N.
  - The FSM pops at edge N+1, and `txd` falls after edge N+1.
- **Frame length**: exactly 10·D clocks, where D is the divisor in effect.
- **Register updates**: STATUS, DIV and CTRL changes become visible to reads on the cycle after the write edge.
- **Read timing**: reads are combinational in the same cycle, like the data RAM.

## Configuration
- Macro `UART_TX_IRQ_EN`.
- **Defined**:
  - Port `tx_irq` exists.
  - CTRL bit0 is `irq_en` (R/W); the other CTRL bits read 0.
  - `tx_irq` = `irq_en` & `empty` & !`busy`, registered with one cycle of lag.
- **Undefined**:
  - The `tx_irq` port is absent.
  - CTRL reads 0 and writes to it are ignored.

## Structure
- `defines.v` holds:
  - register offsets `UART_TXDATA`, `UART_STATUS`, `UART_DIV`, `UART_CTRL`;
  - STATUS bit positions;
  - FSM state encodings;
  - the default `CLK_DIV`.
- Sub-module `uart_tx_fifo`: a synchronous FIFO.
  - Parameters: width 8 and `FIFO_DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
  - The same `clk`/`rst` as the top.
- The top holds the bus decode, the register file and the FSM.

## Test plan
- **Reset idle**: after reset, STATUS reads 0x0000_0002, DIV reads 434, and `txd` = 1.
- **Single frame**: with DIV = 4, write 0x55 to TXDATA.
  - `txd` reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each for 4 clocks.
  - The frame is 40 clocks, starting one cycle after the write edge.
  - `busy` is 0 afterwards.
- **Back-to-back**: with DIV = 2, write 0xA5 then 0x0F on consecutive cycles.
  - The second start bit follows the first stop bit with zero idle clocks.
  - Total 40 clocks.
- **Overflow**: with DIV = 100, write 10 bytes in consecutive cycles (FIFO_DEPTH = 8).
  - `full` = 1 and `ovf` = 1, and exactly 9 bytes are transmitted (one popped early).
  - Writing STATUS = 0x8 clears `ovf`.
- **Decode**: a write to BASE+0x10 changes nothing; a read of BASE+0x10 returns 0; reads with `ce` = 0 return 0.
- **IRQ** (`UART_TX_IRQ_EN`): set CTRL = 1, send 1 byte with DIV = 4.
  - `tx_irq` drops during the frame.
  - It rises one cycle after `busy` falls.
- **Reset mid-frame**: assert `rst` mid-frame; `txd` = 1 immediately.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register offsets, STATUS bit positions, FSM state
// encodings and the default divisor shared by the UART transmitter files.
package mmio_uart_tx_pkg;

    // Register select values, taken from addr[3:2]
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT_LO = 8;

    // Default clocks per bit
    localparam logic [15:0] UART_CLK_DIV_DEFAULT = 16'd434;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // A divisor of zero still gives a one-clock bit
    function automatic logic [15:0] bit_time(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: data-RAM style bus (ce/we/addr/data) seen by the UART.
interface mmio_uart_tx_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output ce, output we, output addr, output data_i, input data_o);
    modport slave  (input ce, input we, input addr, input data_i, output data_o);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// uart_tx_fifo: synchronous TX byte FIFO. Push into a full FIFO and pop
// from an empty one are ignored; fullness is judged on the pre-edge count.
module uart_tx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; emptiness is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the data-RAM bus.
// Optional macro UART_TX_IRQ_EN adds CTRL.irq_en and the tx_irq output.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [15:0] CLK_DIV    = UART_CLK_DIV_DEFAULT,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    mmio_uart_tx_if.slave   bus,
`ifdef UART_TX_IRQ_EN
    output logic            tx_irq,
`endif
    output logic            txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit, wr, rd;
    logic [1:0]    sel;
    logic          wr_txdata;
    logic          push, pop;
    logic [7:0]    fifo_dout;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [3:0]    cnt4;
    logic          ovf;
    logic [15:0]   div_q;
    logic          irq_en;
    tx_state_e     state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   timer;
    logic          bit_end;
    logic [15:0]   reload;
    logic          busy;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign hit       = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign sel       = bus.addr[3:2];
    assign wr        = hit && bus.we;
    assign rd        = hit && !bus.we;
    assign wr_txdata = wr && (sel == UART_TXDATA);
    assign push      = wr_txdata && !full;
    assign cnt4      = 4'(count);
    assign busy      = (state != S_IDLE);
    assign bit_end   = (timer == 16'd1);
    assign reload    = bit_time(div_q);
    // Pop on leaving IDLE or at the end of a stop bit with more data queued
    assign pop       = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
    assign unused_bits = ^{bus.addr[1:0], bus.data_i[31:16]};

    uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.data_i[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Register file: sticky overflow with W1C, divisor
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf   <= 1'b0;
            div_q <= CLK_DIV;
        end else begin
            if (wr_txdata && full)
                ovf <= 1'b1;
            else if (wr && sel == UART_STATUS && bus.data_i[STAT_OVF])
                ovf <= 1'b0;
            if (wr && sel == UART_DIV)
                div_q <= bus.data_i[15:0];
        end
    end

`ifdef UART_TX_IRQ_EN
    // CTRL.irq_en and the lagged idle-and-drained interrupt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en <= 1'b0;
            tx_irq <= 1'b0;
        end else begin
            if (wr && sel == UART_CTRL)
                irq_en <= bus.data_i[0];
            tx_irq <= irq_en && empty && !busy;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    // Frame FSM; txd is registered and the bit timer reloads at every boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            shift   <= 8'h00;
            bit_idx <= 3'd0;
            timer   <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (!empty) begin
                        shift <= fifo_dout;
                        timer <= reload;
                        txd   <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        timer   <= reload;
                        txd     <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer   <= reload;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            txd   <= shift[0];
                            shift <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        timer <= reload;
                        if (!empty) begin
                            shift <= fifo_dout;
                            txd   <= 1'b0;
                            state <= S_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Side-effect-free combinational read mux
    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (sel)
                UART_STATUS: begin
                    rdata[STAT_FULL]  = full;
                    rdata[STAT_EMPTY] = empty;
                    rdata[STAT_BUSY]  = busy;
                    rdata[STAT_OVF]   = ovf;
                    rdata[STAT_CNT_LO +: 4] = cnt4;
                end
                UART_DIV:  rdata[15:0] = div_q;
                UART_CTRL: rdata[0]    = irq_en;
                default:   rdata       = 32'h0;
            endcase
        end
    end

    assign bus.data_o = rdata;

endmodule
